// File: rtl/mul_share_arb_pkg.sv
// mul_share_arb_pkg: widths, pipeline depth and operand slicing shared by the multiplier arbiter.
package mul_share_arb_pkg;
    localparam int OPW = 16;
    localparam int PW = 24;
    localparam int MUL_LAT = 3;

    function automatic int op_lo(input int i);
        return i * OPW;
    endfunction
endpackage

// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester operand handshake and result handshake bundle.
interface mul_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW = 2
);
    import mul_share_arb_pkg::*;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic res_valid;
    logic res_ready;
    logic [IDW-1:0] res_id;
    logic [PW-1:0] res_p;
    logic busy;
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input req_ready, res_valid, res_id, res_p, busy
    );
    modport slave (
        input req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_p, busy
    );
endinterface

// File: rtl/mul_share_arb_dsp.sv
// mul_share_arb_dsp: three-register signed 16x16 multiply truncated to 24 bits, stalled by ce.
module mul_share_arb_dsp
    import mul_share_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  ce,
    input  logic signed [OPW-1:0] a,
    input  logic signed [OPW-1:0] b,
    output logic        [PW-1:0]  p
);
    logic signed [OPW-1:0] a_q;
    logic signed [OPW-1:0] b_q;
    logic [PW-1:0] m_q;
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q <= a;
            b_q <= b;
            m_q <= PW'(32'(a_q) * 32'(b_q));
            p <= m_q;
        end
    end
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter feeding one shared pipelined multiplier with id tracking.
module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW = 2,
    parameter int MUL_LAT = mul_share_arb_pkg::MUL_LAT
) (
    input logic clk,
    input logic reset,
    mul_share_arb_if.slave bus
);
    import mul_share_arb_pkg::*;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] idx;
    logic found;
    logic ce;
    logic [MUL_LAT-1:0] v;
    logic [IDW-1:0] id_q [MUL_LAT];
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;

    assign ce = !v[MUL_LAT-1] || bus.res_ready;

    always_comb begin
        found = 1'b0;
        gid = last_grant;
        idx = last_grant;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last_grant) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gid = idx;
            end
        end
    end

    // Gating with reset keeps req_ready low while the chain is held cleared.
    assign bus.req_ready = (found && ce && reset) ? NREQ'(1) << gid : '0;
    assign op_a = bus.req_a[op_lo(int'(gid)) +: OPW];
    assign op_b = bus.req_b[op_lo(int'(gid)) +: OPW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (ce) begin
            v <= {v[MUL_LAT-2:0], found};
            if (found) last_grant <= gid;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            id_q[0] <= gid;
            for (int i = 1; i < MUL_LAT; i++) id_q[i] <= id_q[i-1];
        end
    end

    mul_share_arb_dsp u_dsp (
        .clk(clk),
        .ce(ce),
        .a(op_a),
        .b(op_b),
        .p(bus.res_p)
    );

    assign bus.res_valid = v[MUL_LAT-1];
    assign bus.res_id = id_q[MUL_LAT-1];
    assign bus.busy = |v;
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed vectors for latency, round-robin order, truncation, backpressure and reset.
module tb_mul_share_arb;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errs = 0;
    int pa [4] = '{100, -200, 300, -400};
    int pb [4] = '{7, 7, -7, -7};

    mul_share_arb_if #(.NREQ(4), .IDW(2)) bus ();

    mul_share_arb #(.NREQ(4), .IDW(2), .MUL_LAT(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] p24(input int x);
        logic [23:0] t;
        t = x[23:0];
        return {8'h00, t};
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        bus.req_a[16*i +: 16] = a[15:0];
        bus.req_b[16*i +: 16] = b[15:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic one_op(input int i, input int a, input int b, input logic [23:0] p);
        int lat;
        @(negedge clk);
        set_op(i, a, b);
        bus.req_valid = 4'(1 << i);
        #1 chk("op_ready", 32'(bus.req_ready), 32'(1 << i));
        @(negedge clk);
        bus.req_valid = '0;
        lat = 1;
        while (!bus.res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("op_latency", lat, 3);
        chk("op_id", 32'(bus.res_id), i);
        chk("op_p", 32'(bus.res_p), {8'h00, p});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = 1'b1;
        bus.req_valid = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        reset = 1'b1;

        one_op(0, 3, -5, 24'hFFFFF1);
        one_op(2, 32'h7FFF, 32'h7FFF, 24'hFF0001);
        one_op(1, -32768, -32768, 24'h000000);
        one_op(3, -1, 1, 24'hFFFFFF);

        // all four requesters: grants and results rotate 0,1,2,3
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, pa[i], pb[i]);
        @(negedge clk);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #1 chk("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k >= 3) begin
                chk("rr_valid", 32'(bus.res_valid), 1);
                chk("rr_id", 32'(bus.res_id), (k - 3) % 4);
                chk("rr_p", 32'(bus.res_p), p24(pa[(k-3)%4] * pb[(k-3)%4]));
            end
            @(negedge clk);
        end
        bus.req_valid = '0;

        // backpressure with three operations in flight
        do_reset();
        for (int i = 0; i < 3; i++) set_op(i, i + 2, -(i + 3));
        @(negedge clk);
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_grant", 32'(bus.req_ready), 32'(1 << k));
            @(negedge clk);
            bus.req_valid[k] = 1'b0;
        end
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready", 32'(bus.req_ready), 0);
            chk("bp_valid", 32'(bus.res_valid), 1);
            chk("bp_id", 32'(bus.res_id), 0);
            chk("bp_p", 32'(bus.res_p), p24(-6));
            chk("bp_busy", 32'(bus.busy), 1);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rel_valid", 32'(bus.res_valid), 1);
            chk("bp_rel_id", 32'(bus.res_id), k);
            chk("bp_rel_p", 32'(bus.res_p), p24((k + 2) * -(k + 3)));
        end
        @(negedge clk);
        chk("bp_drain_valid", 32'(bus.res_valid), 0);
        chk("bp_drain_busy", 32'(bus.busy), 0);

        // reset while two operations are in flight
        do_reset();
        set_op(0, 5, 5);
        set_op(1, 6, 6);
        set_op(2, 7, 7);
        @(negedge clk);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("mr_pre_valid", 32'(bus.res_valid), 1);
        reset = 1'b0;
        bus.req_valid = 4'b0101;
        #1 chk("mr_valid", 32'(bus.res_valid), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("mr_first_grant", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mr_no_stale", 32'(bus.res_valid), 0);
        end

        // fairness between requesters 1 and 3
        do_reset();
        set_op(1, -9, 9);
        set_op(3, 1000, 1000);
        @(negedge clk);
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_ready", 32'(bus.req_ready), (k % 2 == 1) ? 32'b1000 : 32'b0010);
            if (k >= 3) begin
                chk("fair_id", 32'(bus.res_id), ((k - 3) % 2 == 0) ? 1 : 3);
                chk("fair_p", 32'(bus.res_p), ((k - 3) % 2 == 0) ? p24(-81) : p24(1000000));
            end
            @(negedge clk);
        end
        bus.req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
